// File: rtl/psd_pkg.sv
// Shared constants and state encoding for the sequential nibble-lane subtractor.
package psd_pkg;

    localparam int LANE_W = 4;
    localparam int LANES  = 16 / LANE_W;

    localparam logic [3:0] SAT_POS = 4'h7;
    localparam logic [3:0] SAT_NEG = 4'h8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } psd_state_t;

endpackage

// File: rtl/psd_16bit_seq_if.sv
// Start/done coprocessor bus between the execute stage and psd_16bit_seq.
interface psd_16bit_seq_if;
    import psd_pkg::*;

    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Diff;
    logic [3:0]  lane_err;
    logic        Error;

    modport master (output start, A, B, input busy, done, Diff, lane_err, Error);
    modport slave  (input start, A, B, output busy, done, Diff, lane_err, Error);

endinterface

// File: rtl/psd_lane_4bit.sv
// One signed nibble lane: a - b, saturating by default, modulo-16 when PSD_WRAP_EN is defined.
module psd_lane_4bit
    import psd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] diff,
    output logic       ovfl
);

    logic [4:0] d_s;

    // Lane difference with overflow detect and result select
    always_comb begin
        d_s  = {a[3], a} - {b[3], b};
        // Overflow exactly when the 5-bit result does not fit in 4 signed bits
        ovfl = d_s[4] ^ d_s[3];
`ifdef PSD_WRAP_EN
        diff = d_s[3:0];
`else
        case ({d_s[4], d_s[3]})
            2'b01:   diff = SAT_POS;
            2'b10:   diff = SAT_NEG;
            default: diff = d_s[3:0];
        endcase
`endif
    end

endmodule

// File: rtl/psd_16bit_seq.sv
// Multi-cycle 16-bit sub-word subtractor, one nibble lane per cycle, results published on done.
// Build option: PSD_WRAP_EN selects wrapping lanes instead of saturation.
module psd_16bit_seq
    import psd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    psd_16bit_seq_if.slave    bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]  state_r;
    logic [1:0]  idx_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [15:0] shadow_r;
    logic [3:0]  shadow_err_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] diff_r;
    logic [3:0]  lane_err_r;
    logic        error_r;

    logic [3:0]  lane_a_s;
    logic [3:0]  lane_b_s;
    logic [3:0]  lane_diff_s;
    logic        lane_ovfl_s;
    logic [15:0] shadow_nxt_s;
    logic [3:0]  err_nxt_s;

    // Select the current lane operands from the latched words
    always_comb begin
        lane_a_s = a_r[{idx_r, 2'b00} +: LANE_W];
        lane_b_s = b_r[{idx_r, 2'b00} +: LANE_W];
    end

    psd_lane_4bit u_lane (
        .a    (lane_a_s),
        .b    (lane_b_s),
        .diff (lane_diff_s),
        .ovfl (lane_ovfl_s)
    );

    // Merge the freshly computed lane into the shadow result
    always_comb begin
        shadow_nxt_s                              = shadow_r;
        shadow_nxt_s[{idx_r, 2'b00} +: LANE_W]    = lane_diff_s;
        err_nxt_s                                 = shadow_err_r;
        err_nxt_s[idx_r]                          = lane_ovfl_s;
    end

    // Sequencer: accept, walk the lanes, publish the whole word at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            idx_r        <= 2'd0;
            a_r          <= 16'h0000;
            b_r          <= 16'h0000;
            shadow_r     <= 16'h0000;
            shadow_err_r <= 4'h0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            diff_r       <= 16'h0000;
            lane_err_r   <= 4'h0;
            error_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        a_r          <= bus.A;
                        b_r          <= bus.B;
                        shadow_r     <= 16'h0000;
                        shadow_err_r <= 4'h0;
                        idx_r        <= 2'd0;
                        busy_r       <= 1'b1;
                        state_r      <= S_RUN;
                    end else begin
                        state_r      <= S_IDLE;
                    end
                end
                S_RUN: begin
                    shadow_r     <= shadow_nxt_s;
                    shadow_err_r <= err_nxt_s;
                    if (idx_r == 2'd3) begin
                        diff_r     <= shadow_nxt_s;
                        lane_err_r <= err_nxt_s;
                        error_r    <= |err_nxt_s;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= S_DONE;
                    end else begin
                        idx_r      <= idx_r + 2'd1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.Diff     = diff_r;
    assign bus.lane_err = lane_err_r;
    assign bus.Error    = error_r;

endmodule

// File: tb/tb_psd_16bit_seq.sv
// Scoreboard bench for psd_16bit_seq: directed vectors, expected results queued at issue time.
module tb_psd_16bit_seq;

    typedef struct {
        logic [15:0] diff;
        logic [3:0]  le;
        logic        err;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   edge_cnt;
    int   n_checks;
    int   n_fail;
    exp_t q[$];

    psd_16bit_seq_if bus ();

    psd_16bit_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one accepted operation; done is due four edges after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] d, input logic [3:0] le);
        exp_t e;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        e.diff = d;
        e.le   = le;
        e.err  = |le;
        e.due  = edge_cnt + 5;
        q.push_back(e);
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            step(1);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
        step(1);
    endtask

    // Monitor: compare published results, done width and output hold against the scoreboard
    initial begin
        exp_t e;
        exp_t last;
        logic prev_done;
        last.diff = 16'h0000;
        last.le   = 4'h0;
        last.err  = 1'b0;
        last.due  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last.diff = 16'h0000;
                last.le   = 4'h0;
                last.err  = 1'b0;
                prev_done = 1'b0;
            end else if (bus.done) begin
                chk("done_width", prev_done, 1'b0);
                chk("busy_at_done", bus.busy, 1'b0);
                if (q.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("Diff", bus.Diff, e.diff);
                    chk("lane_err", bus.lane_err, e.le);
                    chk("Error", bus.Error, e.err);
                    chk("latency", edge_cnt, e.due);
                    last = e;
                end
                prev_done = 1'b1;
            end else begin
                chk("Diff_hold", bus.Diff, last.diff);
                chk("lane_err_hold", bus.lane_err, last.le);
                prev_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        edge_cnt  = 0;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = 16'h0000;
        bus.B     = 16'h0000;
        step(2);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_Diff", bus.Diff, 16'h0000);
        chk("rst_lane_err", bus.lane_err, 4'h0);
        chk("rst_Error", bus.Error, 1'b0);
        rst_n = 1'b1;
        step(1);

        // Reset in the middle of RUN discards the operation
        bus.A     = 16'h7654;
        bus.B     = 16'h1111;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("busy_run", bus.busy, 1'b1);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("midrun_busy", bus.busy, 1'b0);
        chk("midrun_done", bus.done, 1'b0);
        chk("midrun_Diff", bus.Diff, 16'h0000);
        chk("midrun_lane_err", bus.lane_err, 4'h0);
        chk("midrun_Error", bus.Error, 1'b0);
        step(2);
        chk("midrun_done_held", bus.done, 1'b0);
        rst_n = 1'b1;
        step(6);

        issue(16'h7654, 16'h1111, 16'h6543, 4'b0000);
        drain();

`ifdef PSD_WRAP_EN
        issue(16'h8007, 16'h100F, 16'h7008, 4'b1001);
        drain();
        issue(16'h0000, 16'h8888, 16'h8888, 4'b1111);
        drain();
        issue(16'h7777, 16'h8888, 16'hFFFF, 4'b1111);
        drain();
`else
        issue(16'h8007, 16'h100F, 16'h8007, 4'b1001);
        drain();
        issue(16'h0000, 16'h8888, 16'h7777, 4'b1111);
        drain();
        issue(16'h7777, 16'h8888, 16'h7777, 4'b1111);
        drain();
`endif

        // start during RUN is ignored
        issue(16'h0000, 16'h0000, 16'h0000, 4'b0000);
        step(1);
        bus.A     = 16'hFFFF;
        bus.B     = 16'h1111;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("busy_ignore", bus.busy, 1'b1);
        drain();
        step(6);
        chk("no_second_op", q.size(), 0);

        // start held high: accepted again in the DONE cycle
        begin
            exp_t e;
            bus.A     = 16'h3333;
            bus.B     = 16'h1111;
            bus.start = 1'b1;
            e.diff = 16'h2222; e.le = 4'b0000; e.err = 1'b0; e.due = edge_cnt + 5;
            q.push_back(e);
            step(5);
            chk("b2b_done_cycle", bus.done, 1'b1);
            bus.A = 16'h0000;
            bus.B = 16'h7777;
            e.diff = 16'h9999; e.le = 4'b0000; e.err = 1'b0; e.due = edge_cnt + 5;
            q.push_back(e);
            step(1);
            bus.start = 1'b0;
            chk("b2b_busy", bus.busy, 1'b1);
            drain();
        end

        // Operands change every cycle after acceptance
        issue(16'h0123, 16'h0011, 16'h0112, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            bus.A = 16'($urandom);
            bus.B = 16'($urandom);
            step(1);
        end
        drain();
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
